alarm_melody_sequencer: RTL

Sequences a fixed eight-note alarm melody and drives the half-period `tone` word consumed by the downstream tone generator, plus a `mute` qualifier that gates the buzzer during rests and inter-note gaps. The block starts on the alarm-match pulse from the clock/compare logic and loops the melody until dismissed, or until a repeat limit if that feature is compiled in. It sits between the alarm comparator and the tone generator/buzzer output gate.

---
 rtl/alarm_melody_sequencer_if.sv | 21 ++
 rtl/alarm_melody_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alarm_melody_sequencer_if.sv
// Control/status bundle between the alarm logic and the melody sequencer.
// The alarm side is the master; the sequencer is the slave.
interface alarm_melody_sequencer_if;
    logic        start;
    logic        stop;
    logic [21:0] tone;
    logic        mute;
    logic        playing;
    logic [2:0]  note_idx;
    logic        done;

    modport master (
        output start, stop,
        input  tone, mute, playing, note_idx, done
    );

    modport slave (
        input  start, stop,
        output tone, mute, playing, note_idx, done
    );
endinterface

// File: rtl/alarm_melody_sequencer.sv
// Eight-note alarm melody sequencer driving the tone generator's half-period word.
// Define ALARM_REPEAT_LIMIT_EN to auto-stop after REPEATS loops with a done pulse.
module alarm_melody_sequencer #(
    parameter int unsigned BEAT_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 1_250_000,
    parameter int unsigned REPEATS     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    alarm_melody_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_NOTE,
        S_GAP
    } state_e;

    localparam logic [23:0] BEAT_LAST = 24'(BEAT_CYCLES - 1);
    localparam logic [23:0] GAP_LAST  = 24'(GAP_CYCLES - 1);

    function automatic logic [21:0] rom_tone(input logic [2:0] idx);
        case (idx)
            3'd0:    rom_tone = 22'd47777;
            3'd1:    rom_tone = 22'd37920;
            3'd2:    rom_tone = 22'd31887;
            3'd3:    rom_tone = 22'd23888;
            3'd5:    rom_tone = 22'd31887;
            3'd6:    rom_tone = 22'd23888;
            default: rom_tone = 22'd0;
        endcase
    endfunction

    function automatic logic [1:0] rom_beats(input logic [2:0] idx);
        case (idx)
            3'd3, 3'd6: rom_beats = 2'd2;
            3'd7:       rom_beats = 2'd3;
            default:    rom_beats = 2'd1;
        endcase
    endfunction

    state_e      state_q;
    logic [2:0]  idx_q;
    logic [21:0] tone_q;
    logic        mute_q;
    logic        playing_q;
    logic [23:0] beat_cnt_q;
    logic [1:0]  beat_num_q;

    logic [2:0]  next_idx;
    logic [21:0] next_tone;
    logic        beat_end;
    logic        note_end;
    logic        gap_end;
    logic        advance;
    logic        last_loop;

    // idx 7 + 1 wraps to 0 in three bits, which is exactly the melody restart.
    assign next_idx  = idx_q + 3'd1;
    assign next_tone = rom_tone(next_idx);
    assign beat_end  = (beat_cnt_q == BEAT_LAST);
    assign note_end  = beat_end && (beat_num_q == rom_beats(idx_q) - 2'd1);
    assign gap_end   = (beat_cnt_q == GAP_LAST);

    always_comb begin
        advance = 1'b0;
        case (state_q)
            S_NOTE:  advance = note_end && (GAP_CYCLES == 0);
            S_GAP:   advance = gap_end;
            default: advance = 1'b0;
        endcase
    end

`ifdef ALARM_REPEAT_LIMIT_EN
    logic [7:0] loop_q;
    logic       done_q;
    logic       wrap;

    assign wrap      = (idx_q == 3'd7);
    assign last_loop = wrap && ((loop_q + 8'd1) == 8'(REPEATS));

    always_ff @(posedge clk) begin
        if (rst) begin
            loop_q <= 8'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.stop || state_q == S_IDLE) begin
                loop_q <= 8'd0;
            end else if (advance && wrap) begin
                if (last_loop) begin
                    loop_q <= 8'd0;
                    done_q <= 1'b1;
                end else begin
                    loop_q <= loop_q + 8'd1;
                end
            end
        end
    end

    assign bus.done = done_q;
`else
    assign last_loop = 1'b0;
    assign bus.done  = 1'b0;
`endif

    // NOTE: reset is synchronous and every register here is state, so all use
    // non-blocking assignments; the melody ROM is pure logic and needs no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            tone_q     <= 22'd0;
            mute_q     <= 1'b1;
            playing_q  <= 1'b0;
            beat_cnt_q <= 24'd0;
            beat_num_q <= 2'd0;
        end else if (bus.stop) begin
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            tone_q     <= 22'd0;
            mute_q     <= 1'b1;
            playing_q  <= 1'b0;
            beat_cnt_q <= 24'd0;
            beat_num_q <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q    <= S_NOTE;
                        idx_q      <= 3'd0;
                        tone_q     <= rom_tone(3'd0);
                        mute_q     <= (rom_tone(3'd0) == 22'd0);
                        playing_q  <= 1'b1;
                        beat_cnt_q <= 24'd0;
                        beat_num_q <= 2'd0;
                    end
                end
                default: begin
                    if (advance && last_loop) begin
                        state_q    <= S_IDLE;
                        idx_q      <= 3'd0;
                        tone_q     <= 22'd0;
                        mute_q     <= 1'b1;
                        playing_q  <= 1'b0;
                        beat_cnt_q <= 24'd0;
                        beat_num_q <= 2'd0;
                    end else if (advance) begin
                        state_q    <= S_NOTE;
                        idx_q      <= next_idx;
                        tone_q     <= next_tone;
                        mute_q     <= (next_tone == 22'd0);
                        beat_cnt_q <= 24'd0;
                        beat_num_q <= 2'd0;
                    end else if (state_q == S_NOTE && note_end) begin
                        // Tone word holds through the gap; only the mute qualifier drops.
                        state_q    <= S_GAP;
                        mute_q     <= 1'b1;
                        beat_cnt_q <= 24'd0;
                        beat_num_q <= 2'd0;
                    end else if (state_q == S_NOTE && beat_end) begin
                        beat_cnt_q <= 24'd0;
                        beat_num_q <= beat_num_q + 2'd1;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + 24'd1;
                    end
                end
            endcase
        end
    end

    assign bus.tone     = tone_q;
    assign bus.mute     = mute_q;
    assign bus.playing  = playing_q;
    assign bus.note_idx = idx_q;
endmodule
